// File: rtl/lock_entry_ctrl_if.sv
// Keypad strobe/code bundle shared by the keypad decoder (master) and the lock controller (slave).
interface lock_entry_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;

  modport master (output key_valid, output key_code);
  modport slave  (input  key_valid, input  key_code);
endinterface

// File: rtl/lock_entry_ctrl.sv
// Six-digit lock sequencer: captures keypad digits, checks them against the stored
// password and runs the open / fail / lockout / change-password state machine.
module lock_entry_ctrl #(
  parameter logic [23:0] DEFAULT_PW     = 24'h123456,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset_switch_n,
  lock_entry_ctrl_if.slave    keys,
  output logic [3:0]          out1,
  output logic [3:0]          out2,
  output logic [3:0]          out3,
  output logic [3:0]          out4,
  output logic [3:0]          out5,
  output logic [3:0]          out6,
  output logic [2:0]          digit_cnt,
  output logic                unlocked,
  output logic                alarm,
  output logic [2:0]          fail_cnt
);

  localparam int unsigned TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_OPEN = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    TRIES  = 3'(MAX_TRIES);

  typedef enum logic [2:0] {ENTRY, CHECK, OPEN, SETPW, LOCKOUT} state_t;

  state_t            state, state_next;
  logic [0:5][3:0]   digits;   // digits[0] is the first key typed, lands in the MSB nibble
  logic [23:0]       pw;
  logic [TW-1:0]     timer;
  logic              is_digit, is_enter, is_clear, is_change;
  logic              full, match, timer_zero;
  logic [2:0]        fail_inc;

  assign is_digit   = keys.key_valid && (keys.key_code <= 4'd9);
  assign is_enter   = keys.key_valid && (keys.key_code == 4'hA);
  assign is_clear   = keys.key_valid && (keys.key_code == 4'hB);
  assign is_change  = keys.key_valid && (keys.key_code == 4'hC);
  assign full       = (digit_cnt == 3'd6);
  assign match      = (digits == pw);
  assign timer_zero = (timer == '0);
  assign fail_inc   = (fail_cnt == TRIES) ? fail_cnt : fail_cnt + 3'd1;

  assign {out1, out2, out3, out4, out5, out6} = digits;

  always_ff @(posedge clk or negedge reset_switch_n) begin
    if (!reset_switch_n) state <= ENTRY;
    else                 state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ENTRY:   if (is_enter && full) state_next = CHECK;
      CHECK: begin
        if (match)                  state_next = OPEN;
        else if (fail_inc == TRIES) state_next = LOCKOUT;
        else                        state_next = ENTRY;
      end
      // A key pressed in the final OPEN cycle takes priority over the timeout.
      OPEN: begin
        if (is_enter)        state_next = ENTRY;
        else if (is_change)  state_next = SETPW;
        else if (timer_zero) state_next = ENTRY;
      end
      SETPW:   if (is_enter && full) state_next = ENTRY;
      LOCKOUT: if (timer_zero) state_next = ENTRY;
      default: state_next = ENTRY;
    endcase
  end

  always_comb begin
    unlocked = (state == OPEN) || (state == SETPW);
    alarm    = (state == LOCKOUT);
  end

  always_ff @(posedge clk or negedge reset_switch_n) begin
    if (!reset_switch_n) begin
      digits    <= '0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      timer     <= '0;
      pw        <= DEFAULT_PW;
    end else begin
      case (state)
        ENTRY, SETPW: begin
          if (is_clear) begin
            digits    <= '0;
            digit_cnt <= '0;
          end else if (is_digit && !full) begin
            digits[digit_cnt] <= keys.key_code;
            digit_cnt         <= digit_cnt + 3'd1;
          end else if (state == SETPW && is_enter && full) begin
            pw        <= digits;
            digits    <= '0;
            digit_cnt <= '0;
          end
        end
        CHECK: begin
          digits    <= '0;
          digit_cnt <= '0;
          if (match) begin
            fail_cnt <= '0;
            timer    <= T_OPEN;
          end else begin
            fail_cnt <= fail_inc;
            if (fail_inc == TRIES) timer <= T_LOCK;
          end
        end
        OPEN:    if (!timer_zero) timer <= timer - TW'(1);
        LOCKOUT: begin
          if (timer_zero) fail_cnt <= '0;
          else            timer    <= timer - TW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Bench for lock_entry_ctrl: directed scenarios plus a random key stream, all checked
// against a queue/countdown model of the lock's behaviour.
module tb_lock_entry_ctrl;
  localparam int UNL  = 10;
  localparam int LCK  = 20;
  localparam int MAXT = 3;

  logic       clk = 1'b0;
  logic       reset_switch_n = 1'b0;
  logic [3:0] out1, out2, out3, out4, out5, out6;
  logic [2:0] digit_cnt, fail_cnt;
  logic       unlocked, alarm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lock_entry_ctrl_if kif();

  lock_entry_ctrl #(
    .DEFAULT_PW    (24'h123456),
    .MAX_TRIES     (MAXT),
    .UNLOCK_CYCLES (UNL),
    .LOCKOUT_CYCLES(LCK)
  ) dut (
    .clk           (clk),
    .reset_switch_n(reset_switch_n),
    .keys          (kif),
    .out1          (out1),
    .out2          (out2),
    .out3          (out3),
    .out4          (out4),
    .out5          (out5),
    .out6          (out6),
    .digit_cnt     (digit_cnt),
    .unlocked      (unlocked),
    .alarm         (alarm),
    .fail_cnt      (fail_cnt)
  );

  // Reference model: typed digits as a queue, OPEN/LOCKOUT as remaining-cycle countdowns.
  int          typed[$];
  logic [23:0] m_pw;
  bit          m_check, m_set;
  int          m_open, m_lock, m_fail;

  function automatic void m_reset();
    typed.delete();
    m_pw = 24'h123456; m_check = 0; m_set = 0;
    m_open = 0; m_lock = 0; m_fail = 0;
  endfunction

  function automatic logic [23:0] typed_word();
    logic [23:0] w = '0;
    foreach (typed[i]) w[23-4*i -: 4] = 4'(typed[i]);
    return w;
  endfunction

  function automatic void m_step(input bit kv, input logic [3:0] k);
    bit dig = kv && (k <= 4'd9);
    bit ent = kv && (k == 4'hA);
    bit clr = kv && (k == 4'hB);
    bit chg = kv && (k == 4'hC);
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fail = 0;
    end else if (m_check) begin
      m_check = 0;
      if (typed_word() == m_pw) begin
        m_open = UNL; m_fail = 0;
      end else begin
        if (m_fail < MAXT) m_fail++;
        if (m_fail == MAXT) m_lock = LCK;
      end
      typed.delete();
    end else if (m_open > 0) begin
      if (ent) m_open = 0;
      else if (chg) begin m_open = 0; m_set = 1; end
      else m_open--;
    end else begin
      if (clr) typed.delete();
      else if (dig && typed.size() < 6) typed.push_back(int'(k));
      else if (ent && typed.size() == 6) begin
        if (m_set) begin m_pw = typed_word(); typed.delete(); m_set = 0; end
        else m_check = 1;
      end
    end
  endfunction

  function automatic logic [31:0] exp_vec();
    return {typed_word(), 3'(typed.size()), (m_open > 0) || m_set, m_lock > 0, 3'(m_fail)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {out1, out2, out3, out4, out5, out6, digit_cnt, unlocked, alarm, fail_cnt};
  endfunction

  task automatic cycle(input bit kv, input logic [3:0] k);
    kif.key_valid = kv;
    kif.key_code  = k;
    @(posedge clk);
    m_step(kv, k);
    #1;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'($urandom);
  endtask

  task automatic enter_code(input logic [23:0] code);
    for (int i = 0; i < 6; i++) cycle(1'b1, code[23-4*i -: 4]);
    cycle(1'b1, 4'hA);
  endtask

  task automatic pulse_reset();
    #2 reset_switch_n = 1'b0;
    #1;
    m_reset();
    total++;
    if (dut_vec() !== 32'h0) begin
      bad++; $display("FAIL async_reset: got %h want %h", dut_vec(), 32'h0);
    end
    @(negedge clk);
    reset_switch_n = 1'b1;
  endtask

  task automatic test_reset();
    kif.key_valid = 1'b0;
    kif.key_code  = 4'h0;
    m_reset();
    repeat (2) @(negedge clk);
    total++;
    if (dut_vec() !== 32'h0) begin
      bad++; $display("FAIL reset_state: got %h want %h", dut_vec(), 32'h0);
    end
    reset_switch_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unlock();
    int n = 1;
    enter_code(24'h123456);
    total++;
    if (unlocked !== 1'b0 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL unlock_check_cycle: got %h want %h", dut_vec(), exp_vec());
    end
    cycle(1'b0, 4'h0);
    total++;
    if (dut_vec() !== {24'h0, 3'd0, 1'b1, 1'b0, 3'd0}) begin
      bad++; $display("FAIL unlock_open: got %h want %h", dut_vec(), {24'h0, 3'd0, 1'b1, 1'b0, 3'd0});
    end
    for (int i = 0; i < 50 && unlocked === 1'b1; i++) begin
      cycle(1'b0, 4'h0);
      if (unlocked === 1'b1) n++;
    end
    total++;
    if (n != UNL) begin
      bad++; $display("FAIL unlock_duration: got %0d want %0d", n, UNL);
    end
  endtask

  task automatic test_lockout();
    int n = 1;
    for (int t = 1; t <= MAXT; t++) begin
      enter_code(24'h123457);
      cycle(1'b0, 4'h0);
      total++;
      if (fail_cnt !== 3'(t) || alarm !== (t == MAXT)) begin
        bad++; $display("FAIL lockout_try%0d: got fail=%0d alarm=%b want fail=%0d alarm=%b",
                        t, fail_cnt, alarm, t, t == MAXT);
      end
    end
    for (int i = 0; i < 60 && alarm === 1'b1; i++) begin
      cycle(1'b1, 4'($urandom_range(0, 12)));
      total++;
      if (dut_vec() !== exp_vec() || digit_cnt !== 3'd0) begin
        bad++; $display("FAIL lockout_keys: got %h want %h", dut_vec(), exp_vec());
      end
      if (alarm === 1'b1) n++;
    end
    total++;
    if (n != LCK || fail_cnt !== 3'd0) begin
      bad++; $display("FAIL lockout_duration: got %0d fail=%0d want %0d fail=0", n, fail_cnt, LCK);
    end
  endtask

  task automatic test_short_entry();
    cycle(1'b1, 4'h1); cycle(1'b1, 4'h2); cycle(1'b1, 4'h3); cycle(1'b1, 4'hA);
    cycle(1'b0, 4'h0);
    total++;
    if (digit_cnt !== 3'd3 || unlocked !== 1'b0 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL short_enter: got %h want %h", dut_vec(), exp_vec());
    end
    repeat (9) cycle(1'b1, 4'h7);
    total++;
    if (digit_cnt !== 3'd6 || {out1, out2, out3, out4, out5, out6} !== 24'h123777) begin
      bad++; $display("FAIL digit_saturate: got %h want %h", dut_vec(), exp_vec());
    end
    cycle(1'b1, 4'hB);
    total++;
    if (dut_vec() !== 32'h0) begin
      bad++; $display("FAIL clear: got %h want %h", dut_vec(), 32'h0);
    end
  endtask

  task automatic test_change_pw();
    enter_code(24'h123456);
    cycle(1'b0, 4'h0);
    cycle(1'b1, 4'hC);
    total++;
    if (unlocked !== 1'b1 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL setpw_enter: got %h want %h", dut_vec(), exp_vec());
    end
    enter_code(24'h987654);
    total++;
    if (unlocked !== 1'b0 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL setpw_store: got %h want %h", dut_vec(), exp_vec());
    end
    enter_code(24'h123456);
    cycle(1'b0, 4'h0);
    total++;
    if (unlocked !== 1'b0 || fail_cnt !== 3'd1) begin
      bad++; $display("FAIL old_pw_rejected: got unlocked=%b fail=%0d want 0 1", unlocked, fail_cnt);
    end
    enter_code(24'h987654);
    cycle(1'b0, 4'h0);
    total++;
    if (unlocked !== 1'b1 || fail_cnt !== 3'd0) begin
      bad++; $display("FAIL new_pw_accepted: got unlocked=%b fail=%0d want 1 0", unlocked, fail_cnt);
    end
    cycle(1'b1, 4'hA);
  endtask

  task automatic test_manual_relock();
    enter_code(24'h987654);
    cycle(1'b0, 4'h0);
    cycle(1'b0, 4'h0);
    cycle(1'b0, 4'h0);
    cycle(1'b1, 4'hA);
    total++;
    if (unlocked !== 1'b0 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL manual_relock: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_midop();
    for (int t = 0; t < MAXT; t++) begin
      enter_code(24'h111111);
      cycle(1'b0, 4'h0);
    end
    repeat (5) cycle(1'b0, 4'h0);
    total++;
    if (alarm !== 1'b1) begin
      bad++; $display("FAIL reach_lockout: got alarm=%b want 1", alarm);
    end
    pulse_reset();
    enter_code(24'h123456);
    cycle(1'b0, 4'h0);
    total++;
    if (unlocked !== 1'b1) begin
      bad++; $display("FAIL pw_restored: got unlocked=%b want 1", unlocked);
    end
    cycle(1'b1, 4'hC);
    cycle(1'b1, 4'h4); cycle(1'b1, 4'h4); cycle(1'b1, 4'h4);
    pulse_reset();
    cycle(1'b0, 4'h0);
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL after_setpw_reset: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      int r = $urandom_range(0, 99);
      logic [23:0] pw_now = m_pw;
      if (r < 25) begin
        if (typed.size() < 6) cycle(1'b1, pw_now[23-4*typed.size() -: 4]);
        else                  cycle(1'b1, 4'hA);
      end else if (r < 40) cycle(1'b1, 4'($urandom_range(0, 15)));
      else if (r < 45) cycle(1'b1, 4'hA);
      else if (r < 48) cycle(1'b1, 4'hC);
      else if (r < 50) cycle(1'b1, 4'hB);
      else             cycle(1'b0, 4'($urandom));
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_c%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_short_entry();
    test_change_pw();
    test_manual_relock();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
